// File: rtl/substitute.sv
// substitute: registered AES S-box (forward or inverse), one byte per clock.
// The table is computed as GF(2^8) inversion plus affine transform rather than stored.
module substitute #(
  parameter bit INVERSE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ t : p;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 = product of x^(2^k) for k = 1..7; yields 0 for x = 0 as required
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] s, r;
    s = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
  endfunction
  logic [7:0] mapped;
  always_comb mapped = INVERSE ? ginv(inv_affine(in_byte)) : affine(ginv(in_byte));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_byte <= mapped;
    end
endmodule

// File: tb/tb_substitute.sv
// tb_substitute: directed checks of forward and inverse substitute instances against an independent model.
module tb_substitute;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fv = 1'b0, iv = 1'b0;
  logic [7:0] fb = 8'h00, ib = 8'h00;
  logic fov, iov;
  logic [7:0] fob, iob;
  int checks = 0;
  int failures = 0;
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  substitute #(.INVERSE(1'b0)) u_fwd (.clk(clk), .rst(rst), .in_valid(fv), .in_byte(fb), .out_valid(fov), .out_byte(fob));
  substitute #(.INVERSE(1'b1)) u_inv (.clk(clk), .rst(rst), .in_valid(iv), .in_byte(ib), .out_valid(iov), .out_byte(iob));

  // carry-less product then polynomial reduction by 0x11B
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int y = 1; y < 256; y++) if (ref_mul(x, 8'(y)) == 8'h01) r = 8'(y);
    return r;
  endfunction

  function automatic logic [7:0] ref_affine(input logic [7:0] b);
    logic [7:0] c, o;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      o[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
    return o;
  endfunction

  task automatic build_model();
    for (int x = 0; x < 256; x++) fwd_tab[x] = ref_affine(ref_inv(8'(x)));
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fv = 1'b1; fb = 8'h53; iv = 1'b1; ib = 8'h63;
    tick(); tick();
    checks++;
    if (fob !== 8'h00 || fov !== 1'b0) begin
      failures++;
      $display("FAIL reset_fwd: got byte=%h valid=%b want 00/0", fob, fov);
    end
    checks++;
    if (iob !== 8'h00 || iov !== 1'b0) begin
      failures++;
      $display("FAIL reset_inv: got byte=%h valid=%b want 00/0", iob, iov);
    end
    fv = 1'b0; iv = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forward_vectors();
    logic [7:0] vin [5] = '{8'h00, 8'h01, 8'h53, 8'hFF, 8'h19};
    logic [7:0] vout [5] = '{8'h63, 8'h7C, 8'hED, 8'h16, 8'hD4};
    for (int i = 0; i < 5; i++) begin
      fv = 1'b1; fb = vin[i];
      tick();
      checks++;
      if (fob !== vout[i] || fov !== 1'b1) begin
        failures++;
        $display("FAIL fwd_vec[%0d]: in=%h got %h/%b want %h/1", i, vin[i], fob, fov, vout[i]);
      end
    end
    fv = 1'b0;
    tick();
  endtask

  task automatic test_inverse_vectors();
    logic [7:0] vin [5] = '{8'h63, 8'h7C, 8'hED, 8'h16, 8'hD4};
    logic [7:0] vout [5] = '{8'h00, 8'h01, 8'h53, 8'hFF, 8'h19};
    for (int i = 0; i < 5; i++) begin
      iv = 1'b1; ib = vin[i];
      tick();
      checks++;
      if (iob !== vout[i] || iov !== 1'b1) begin
        failures++;
        $display("FAIL inv_vec[%0d]: in=%h got %h/%b want %h/1", i, vin[i], iob, iov, vout[i]);
      end
    end
    iv = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    int bad_f, bad_i, bad_r;
    bad_f = 0; bad_i = 0; bad_r = 0;
    for (int x = 0; x < 256; x++) begin
      fv = 1'b1; fb = 8'(x); iv = 1'b1; ib = 8'(x);
      tick();
      if (fob !== fwd_tab[x] || fov !== 1'b1) begin
        bad_f++;
        $display("FAIL sweep_fwd: in=%h got %h/%b want %h/1", x[7:0], fob, fov, fwd_tab[x]);
      end
      if (iob !== inv_tab[x] || iov !== 1'b1) begin
        bad_i++;
        $display("FAIL sweep_inv: in=%h got %h/%b want %h/1", x[7:0], iob, iov, inv_tab[x]);
      end
    end
    for (int x = 0; x < 256; x++) begin
      iv = 1'b1; ib = fwd_tab[x];
      tick();
      if (iob !== 8'(x)) begin
        bad_r++;
        $display("FAIL roundtrip: x=%h got %h want %h", x[7:0], iob, x[7:0]);
      end
    end
    fv = 1'b0; iv = 1'b0;
    checks += 3;
    failures += (bad_f != 0) + (bad_i != 0) + (bad_r != 0);
    tick();
  endtask

  task automatic test_hold();
    fv = 1'b1; fb = 8'hA0;
    tick();
    checks++;
    if (fob !== 8'hE0 || fov !== 1'b1) begin
      failures++;
      $display("FAIL hold_load: got %h/%b want e0/1", fob, fov);
    end
    fv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fb = (i % 2 == 0) ? 8'h5A : 8'hC3;
      tick();
      checks++;
      if (fob !== 8'hE0 || fov !== 1'b0) begin
        failures++;
        $display("FAIL hold_idle[%0d]: got %h/%b want e0/0", i, fob, fov);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      fv = 1'b1; fb = 8'h53; iv = 1'b1; ib = 8'hED;
      tick();
      checks++;
      if (fob !== 8'hED || fov !== 1'b1 || iob !== 8'h53 || iov !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back[%0d]: fwd %h/%b inv %h/%b want ed/1 53/1", i, fob, fov, iob, iov);
      end
    end
    fv = 1'b0; iv = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    fv = 1'b1; fb = 8'h9A;
    tick();
    checks++;
    if (fob !== 8'hB8 || fov !== 1'b1) begin
      failures++;
      $display("FAIL async_pre: got %h/%b want b8/1", fob, fov);
    end
    fv = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (fob !== 8'h00 || fov !== 1'b0) begin
      failures++;
      $display("FAIL async_clear: got %h/%b want 00/0", fob, fov);
    end
    fv = 1'b1; fb = 8'h55;
    tick(); tick();
    checks++;
    if (fob !== 8'h00 || fov !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got %h/%b want 00/0", fob, fov);
    end
  endtask

  task automatic test_reset_release();
    fv = 1'b1; fb = 8'hE9;
    rst = 1'b0;
    tick();
    checks++;
    if (fob !== 8'h1E || fov !== 1'b1) begin
      failures++;
      $display("FAIL release_first: got %h/%b want 1e/1", fob, fov);
    end
    fv = 1'b0;
    tick();
  endtask

  task automatic test_midstream_reset();
    fv = 1'b1; fb = 8'h01;
    tick();
    fb = 8'h53;
    #2 rst = 1'b1;
    tick();
    fv = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (fob !== 8'h00 || fov !== 1'b0) begin
      failures++;
      $display("FAIL midstream_stale: got %h/%b want 00/0", fob, fov);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_forward_vectors();
    test_inverse_vectors();
    test_sweep();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_reset_release();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
